// File: rtl/prbs_chk_pkg.sv
// Shared types and constants for the PRBS-15 byte checker.
package prbs_chk_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    typedef enum logic {
        SELF_SYNC = 1'b0,
        FREE_RUN  = 1'b1
    } step_mode_t;

    localparam int PRBS_ORDER = 15;
    localparam int TAP_A      = 14;
    localparam int TAP_B      = 13;
    localparam int BYTE_W     = 8;
    localparam int CNT_W      = 8;
    localparam int POP_W      = 4;

    function automatic logic [POP_W-1:0] popcount(input logic [BYTE_W-1:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < BYTE_W; i++) begin
            n = n + POP_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/prbs_checker_if.sv
// Byte bus between a PRBS source/monitor and the checker.
// Optional byte_count member present when PRBS_CHK_BYTE_CNT_EN is defined.
interface prbs_checker_if #(
    parameter int ERR_CNT_W = 16
);
    logic [prbs_chk_pkg::BYTE_W-1:0] data_in;
    logic                            data_valid;
    logic                            clr_cnt;
    logic                            locked;
    logic                            byte_err;
    logic [ERR_CNT_W-1:0]            err_count;
`ifdef PRBS_CHK_BYTE_CNT_EN
    logic [31:0]                     byte_count;

    modport master (
        output data_in, data_valid, clr_cnt,
        input  locked, byte_err, err_count, byte_count
    );
    modport slave (
        input  data_in, data_valid, clr_cnt,
        output locked, byte_err, err_count, byte_count
    );
`else
    modport master (
        output data_in, data_valid, clr_cnt,
        input  locked, byte_err, err_count
    );
    modport slave (
        input  data_in, data_valid, clr_cnt,
        output locked, byte_err, err_count
    );
`endif
endinterface

// File: rtl/prbs15_byte_step.sv
// Eight MSB-first PRBS-15 steps in one cycle; the reference either tracks
// the received bits (self-sync) or runs on its own prediction (free-run).
module prbs15_byte_step
    import prbs_chk_pkg::*;
(
    input  logic [PRBS_ORDER-1:0] s,
    input  logic [BYTE_W-1:0]     data_in,
    input  step_mode_t            mode,
    output logic [PRBS_ORDER-1:0] s_next,
    output logic [BYTE_W-1:0]     mismatch
);
    logic [PRBS_ORDER-1:0] st;
    logic                  rx;
    logic                  p;

    always_comb begin
        st       = s;
        mismatch = '0;
        rx       = 1'b0;
        p        = 1'b0;
        for (int i = 0; i < BYTE_W; i++) begin
            rx                   = data_in[BYTE_W-1-i];
            p                    = st[TAP_A] ^ st[TAP_B];
            mismatch[BYTE_W-1-i] = rx ^ p;
            st                   = {st[PRBS_ORDER-2:0], (mode == FREE_RUN) ? p : rx};
        end
        s_next = st;
    end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS-15 checker: hunt/verify/locked FSM, bit-error count.
// Define PRBS_CHK_BYTE_CNT_EN to add the saturating byte_count output.
module prbs_checker
    import prbs_chk_pkg::*;
#(
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 8,
    parameter int ERR_CNT_W  = 16
)(
    input  logic           CLK,
    input  logic           RST,
    prbs_checker_if.slave  bus
);
    localparam int SUM_W = ((ERR_CNT_W > POP_W) ? ERR_CNT_W : POP_W) + 1;
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

    state_t                state_reg, state_next;
    logic [PRBS_ORDER-1:0] s_reg, s_next, s_step;
    logic                  fill_reg, fill_next;
    logic [CNT_W-1:0]      run_reg, run_next, bad_reg, bad_next;
    logic                  byte_err_reg, byte_err_next;
    logic [ERR_CNT_W-1:0]  err_count_reg, err_count_next, err_sat;
    logic [SUM_W-1:0]      err_sum;
    logic [BYTE_W-1:0]     mismatch;
    logic [POP_W-1:0]      err_bits;
    logic [CNT_W-1:0]      run_inc, bad_inc;
    logic                  clean, run_done, bad_done;
    step_mode_t            step_mode;

    assign step_mode = (state_reg == LOCKED) ? FREE_RUN : SELF_SYNC;

    prbs15_byte_step u_step (
        .s        (s_reg),
        .data_in  (bus.data_in),
        .mode     (step_mode),
        .s_next   (s_step),
        .mismatch (mismatch)
    );

    // An all-zero reference predicts an all-zero stream, so it never counts as clean.
    assign err_bits = popcount(mismatch);
    assign clean    = (mismatch == '0) && (s_reg != '0);
    assign run_inc  = run_reg + CNT_W'(1);
    assign bad_inc  = bad_reg + CNT_W'(1);
    assign run_done = clean && (run_inc == CNT_W'(LOCK_CNT));
    assign bad_done = (err_bits != '0) && (bad_inc == CNT_W'(UNLOCK_CNT));
    assign err_sum  = SUM_W'(err_count_reg) + SUM_W'(err_bits);
    assign err_sat  = (err_sum > SUM_W'(ERR_MAX)) ? ERR_MAX : err_sum[ERR_CNT_W-1:0];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= HUNT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (bus.data_valid) begin
            case (state_reg)
                HUNT:    if (fill_reg) state_next = VERIFY;
                VERIFY:  if (run_done) state_next = LOCKED;
                LOCKED:  if (bad_done) state_next = HUNT;
                default: state_next = HUNT;
            endcase
        end
    end

    always_comb begin
        s_next         = s_reg;
        fill_next      = fill_reg;
        run_next       = run_reg;
        bad_next       = bad_reg;
        byte_err_next  = 1'b0;
        err_count_next = err_count_reg;
        if (bus.data_valid) begin
            s_next = s_step;
            case (state_reg)
                HUNT: begin
                    fill_next = ~fill_reg;
                    run_next  = '0;
                end
                VERIFY: begin
                    run_next = clean ? run_inc : '0;
                    bad_next = '0;
                end
                LOCKED: begin
                    fill_next = 1'b0;
                    if (err_bits != '0) begin
                        byte_err_next  = 1'b1;
                        err_count_next = err_sat;
                        bad_next       = bad_inc;
                    end else begin
                        bad_next = '0;
                    end
                end
                default: fill_next = 1'b0;
            endcase
        end
        if (bus.clr_cnt) begin
            err_count_next = '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s_reg         <= '0;
            fill_reg      <= 1'b0;
            run_reg       <= '0;
            bad_reg       <= '0;
            byte_err_reg  <= 1'b0;
            err_count_reg <= '0;
        end else begin
            s_reg         <= s_next;
            fill_reg      <= fill_next;
            run_reg       <= run_next;
            bad_reg       <= bad_next;
            byte_err_reg  <= byte_err_next;
            err_count_reg <= err_count_next;
        end
    end

    assign bus.locked    = (state_reg == LOCKED);
    assign bus.byte_err  = byte_err_reg;
    assign bus.err_count = err_count_reg;

`ifdef PRBS_CHK_BYTE_CNT_EN
    logic [31:0] byte_count_reg, byte_count_next;

    always_comb begin
        byte_count_next = byte_count_reg;
        if (bus.data_valid && (state_reg == LOCKED) && (byte_count_reg != '1)) begin
            byte_count_next = byte_count_reg + 32'd1;
        end
        if (bus.clr_cnt) begin
            byte_count_next = '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            byte_count_reg <= '0;
        end else begin
            byte_count_reg <= byte_count_next;
        end
    end

    assign bus.byte_count = byte_count_reg;
`endif

endmodule
